// File: rtl/detector_jogada_if.sv
// Play-detector bus: raw keys and enable in, conditioned play events out.
interface detector_jogada_if;
    logic       habilita;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       jogada_invalida;
    logic       timeout;
    logic [2:0] db_estado;

    modport master (
        output habilita, chaves,
        input  jogada, tem_jogada, jogada_invalida, timeout, db_estado
    );

    modport slave (
        input  habilita, chaves,
        output jogada, tem_jogada, jogada_invalida, timeout, db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Input conditioning for the memory game: synchronizes and debounces the button
// vector, validates one-hot plays and times out waits with no accepted press.
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES  = 3000
) (
    input  logic             clock,
    input  logic             reset,
    detector_jogada_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_ONE = DW'(1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE = TW'(1);

    localparam logic [2:0] OCIOSO         = 3'd0;
    localparam logic [2:0] ESPERA         = 3'd1;
    localparam logic [2:0] FILTRA         = 3'd2;
    localparam logic [2:0] AGUARDA_SOLTAR = 3'd3;
    localparam logic [2:0] ESGOTADO       = 3'd4;

    logic [3:0]    s1, s2;
    logic [2:0]    estado, estado_n;
    logic [3:0]    cand, cand_n;
    logic [DW-1:0] cnt_db, cnt_db_n, db_inc;
    logic [TW-1:0] cnt_to, cnt_to_n, to_inc;
    logic [3:0]    jogada_r, jogada_n;
    logic          tem_r, tem_n;
    logic          inv_r, inv_n;
    logic          to_r, to_n;
    logic          accept;

    // Both counters saturate instead of wrapping
    assign db_inc = (cnt_db == DB_MAX) ? cnt_db : cnt_db + DB_ONE;
    assign to_inc = (cnt_to == TO_MAX) ? cnt_to : cnt_to + TO_ONE;

    always_comb begin
        estado_n = estado;
        cand_n   = cand;
        cnt_db_n = cnt_db;
        cnt_to_n = cnt_to;
        jogada_n = jogada_r;
        tem_n    = 1'b0;
        inv_n    = 1'b0;
        to_n     = 1'b0;
        accept   = 1'b0;

        case (estado)
            OCIOSO: begin
                if (bus.habilita) begin
                    estado_n = ESPERA;
                    cnt_to_n = '0;
                end
            end
            ESPERA: begin
                if (!bus.habilita) begin
                    estado_n = OCIOSO;
                end else begin
                    cnt_to_n = to_inc;
                    if (s2 != 4'b0000) begin
                        estado_n = FILTRA;
                        cand_n   = s2;
                        cnt_db_n = DB_ONE;
                        accept   = (DB_ONE >= DB_MAX);
                    end
                end
            end
            FILTRA: begin
                if (!bus.habilita) begin
                    estado_n = OCIOSO;
                end else begin
                    cnt_to_n = to_inc;
                    if (s2 == 4'b0000) begin
                        estado_n = ESPERA;
                    end else if (s2 != cand) begin
                        cand_n   = s2;
                        cnt_db_n = DB_ONE;
                        accept   = (DB_ONE >= DB_MAX);
                    end else begin
                        cnt_db_n = db_inc;
                        accept   = (db_inc >= DB_MAX);
                    end
                end
            end
            AGUARDA_SOLTAR: begin
                if (s2 != 4'b0000) begin
                    cnt_db_n = '0;
                end else if (db_inc >= DB_MAX) begin
                    cnt_db_n = '0;
                    if (bus.habilita) begin
                        estado_n = ESPERA;
                        cnt_to_n = '0;
                    end else begin
                        estado_n = OCIOSO;
                    end
                end else begin
                    cnt_db_n = db_inc;
                end
            end
            ESGOTADO: begin
                if (!bus.habilita) estado_n = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase

        // Acceptance overrides a timeout expiring on the same edge
        if (accept) begin
            estado_n = AGUARDA_SOLTAR;
            cnt_db_n = '0;
            if ($onehot(cand_n)) begin
                jogada_n = cand_n;
                tem_n    = 1'b1;
            end else begin
                inv_n = 1'b1;
            end
        end else if (bus.habilita && (estado == ESPERA || estado == FILTRA) &&
                     to_inc >= TO_MAX) begin
            estado_n = ESGOTADO;
            to_n     = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1       <= '0;
            s2       <= '0;
            estado   <= OCIOSO;
            cand     <= '0;
            cnt_db   <= '0;
            cnt_to   <= '0;
            jogada_r <= '0;
            tem_r    <= 1'b0;
            inv_r    <= 1'b0;
            to_r     <= 1'b0;
        end else begin
            s1       <= bus.chaves;
            s2       <= s1;
            estado   <= estado_n;
            cand     <= cand_n;
            cnt_db   <= cnt_db_n;
            cnt_to   <= cnt_to_n;
            jogada_r <= jogada_n;
            tem_r    <= tem_n;
            inv_r    <= inv_n;
            to_r     <= to_n;
        end
    end

    assign bus.jogada          = jogada_r;
    assign bus.tem_jogada      = tem_r;
    assign bus.jogada_invalida = inv_r;
    assign bus.timeout         = to_r;
    assign bus.db_estado       = estado;
endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: directed scenarios plus random key/enable traffic
// against a sample-history model of the play detector.
module tb_detector_jogada;
    localparam int DB = 3;
    localparam int TO = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;

    detector_jogada_if bus();

    detector_jogada #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int tem_seen = 0;
    int inv_seen = 0;
    int to_seen  = 0;

    // Model: two-stage delay line, then mode flags plus run lengths of the
    // synchronized samples.
    logic [3:0] p1, p2;
    bit         armed, held, expired;
    int         elapsed, run, zero_run;
    logic [3:0] run_val;
    logic [3:0] e_jog;
    bit         e_tem, e_inv, e_to;

    function automatic logic [2:0] exp_state();
        if (held)         return 3'd3;
        else if (expired) return 3'd4;
        else if (armed)   return (run > 0) ? 3'd2 : 3'd1;
        else              return 3'd0;
    endfunction

    task automatic model_reset();
        p1 = '0; p2 = '0;
        armed = 0; held = 0; expired = 0;
        elapsed = 0; run = 0; zero_run = 0; run_val = '0;
        e_jog = '0; e_tem = 0; e_inv = 0; e_to = 0;
    endtask

    task automatic model_step(input bit h, input logic [3:0] c);
        logic [3:0] x;
        x = p2;
        p2 = p1;
        p1 = c;
        e_tem = 0; e_inv = 0; e_to = 0;
        if (held) begin
            zero_run = (x == 4'b0000) ? zero_run + 1 : 0;
            if (zero_run >= DB) begin
                held = 0;
                run = 0;
                if (h) begin
                    armed = 1;
                    elapsed = 0;
                end
            end
        end else if (expired) begin
            if (!h) expired = 0;
        end else if (armed) begin
            if (!h) begin
                armed = 0;
                run = 0;
            end else begin
                elapsed++;
                if (x == 4'b0000) run = 0;
                else if (run > 0 && x == run_val) run++;
                else begin
                    run_val = x;
                    run = 1;
                end
                if (run >= DB) begin
                    held = 1; armed = 0; zero_run = 0; run = 0;
                    if ($countones(run_val) == 1) begin
                        e_jog = run_val;
                        e_tem = 1;
                    end else begin
                        e_inv = 1;
                    end
                end else if (elapsed >= TO) begin
                    expired = 1; armed = 0; run = 0; e_to = 1;
                end
            end
        end else if (h) begin
            armed = 1;
            elapsed = 0;
        end
    endtask

    task automatic check(input string tag);
        if (bus.tem_jogada === 1'b1) tem_seen++;
        if (bus.jogada_invalida === 1'b1) inv_seen++;
        if (bus.timeout === 1'b1) to_seen++;
        checks++;
        assert (bus.jogada === e_jog) else begin
            failures++;
            $error("FAIL %s jogada observed=%b expected=%b", tag, bus.jogada, e_jog);
        end
        checks++;
        assert (bus.tem_jogada === e_tem) else begin
            failures++;
            $error("FAIL %s tem_jogada observed=%b expected=%b", tag, bus.tem_jogada, e_tem);
        end
        checks++;
        assert (bus.jogada_invalida === e_inv) else begin
            failures++;
            $error("FAIL %s jogada_invalida observed=%b expected=%b", tag, bus.jogada_invalida, e_inv);
        end
        checks++;
        assert (bus.timeout === e_to) else begin
            failures++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, bus.timeout, e_to);
        end
        checks++;
        assert (bus.db_estado === exp_state()) else begin
            failures++;
            $error("FAIL %s db_estado observed=%0d expected=%0d", tag, bus.db_estado, exp_state());
        end
    endtask

    task automatic tick(input bit h, input logic [3:0] c, input string tag);
        bus.habilita = h;
        bus.chaves   = c;
        @(posedge clock);
        model_step(h, c);
        #1 check(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1 model_reset();
        check({tag, "_async"});
        repeat (2) begin
            @(posedge clock);
            #1 check({tag, "_hold"});
        end
        reset = 1'b1;
    endtask

    task automatic expect_count(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        bus.habilita = 1'b0;
        bus.chaves   = 4'b0000;
        model_reset();
        #2 check("reset_state");
        @(posedge clock);
        #1 reset = 1'b1;

        // 1: single clean press
        tem_seen = 0;
        tick(1'b1, 4'b0000, "s1_arm");
        repeat (5) tick(1'b1, 4'b0010, "s1_press");
        repeat (6) tick(1'b1, 4'b0000, "s1_release");
        expect_count("s1_tem", tem_seen, 1);
        expect_count("s1_jogada", int'(bus.jogada), 2);

        // 2: long hold gives one event
        tem_seen = 0;
        repeat (50) tick(1'b1, 4'b0100, "s2_hold");
        repeat (6) tick(1'b1, 4'b0000, "s2_release");
        expect_count("s2_tem", tem_seen, 1);

        // 3: one-cycle glitch is filtered out
        tem_seen = 0;
        tick(1'b1, 4'b0001, "s3_glitch");
        repeat (5) tick(1'b1, 4'b0000, "s3_idle");
        expect_count("s3_tem", tem_seen, 0);
        expect_count("s3_jogada", int'(bus.jogada), 4);

        // 4: two keys at once
        tem_seen = 0; inv_seen = 0;
        repeat (5) tick(1'b1, 4'b0011, "s4_multi");
        repeat (6) tick(1'b1, 4'b0000, "s4_release");
        expect_count("s4_inv", inv_seen, 1);
        expect_count("s4_tem", tem_seen, 0);

        // 5: timeout with no keys
        to_seen = 0;
        repeat (25) tick(1'b1, 4'b0000, "s5_wait");
        expect_count("s5_to", to_seen, 1);
        expect_count("s5_state", int'(bus.db_estado), 4);
        tick(1'b0, 4'b0000, "s5_disable");
        expect_count("s5_idle", int'(bus.db_estado), 0);

        // 6: reset in the middle of filtering
        tem_seen = 0;
        repeat (4) tick(1'b1, 4'b1000, "s6_filter");
        expect_count("s6_filtra", int'(bus.db_estado), 2);
        do_reset("s6_reset");
        expect_count("s6_pre_tem", tem_seen, 0);
        repeat (8) tick(1'b1, 4'b1000, "s6_after");
        expect_count("s6_tem", tem_seen, 1);
        expect_count("s6_jogada", int'(bus.jogada), 8);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [3:0] k;
            int         hold;
            bit         h;
            case ($urandom_range(0, 5))
                0, 1:    k = 4'b0000;
                2, 3:    k = 4'(1 << $urandom_range(0, 3));
                default: k = 4'($urandom_range(0, 15));
            endcase
            hold = $urandom_range(1, 8);
            h = ($urandom_range(0, 9) != 0);
            repeat (hold) tick(h, k, "rand");
            if ($urandom_range(0, 39) == 0) do_reset("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
